// File: rtl/sdpram_fifo_ctrl.sv
// Synchronous FIFO controller sequencing one simple dual-port RAM as storage.
// A 3-entry output buffer and read credits hide the RAM's 2-cycle read latency.
module sdpram_fifo_ctrl #(
    parameter int DWIDTH = 18,
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DWIDTH-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DWIDTH-1:0] rd_data,
    output logic [AWIDTH+1:0] count,
    output logic              ram_en_a,
    output logic              ram_write_a,
    output logic [DWIDTH-1:0] ram_wr_data_a,
    output logic [AWIDTH-1:0] ram_addr_a,
    output logic              ram_en_b,
    output logic [AWIDTH-1:0] ram_addr_b,
    input  logic [DWIDTH-1:0] ram_rd_data_b
);

    localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH-1:0] rptr;
    logic [AWIDTH:0]   ram_cnt;
    logic [AWIDTH:0]   avail_cnt;
    logic [AWIDTH:0]   avail_eff;
    logic              wr_fire_d;
    logic [1:0]        rv_q;
    logic [1:0]        buf_cnt;
    logic [1:0]        bhead;
    logic [1:0]        btail;
    logic [DWIDTH-1:0] bmem [0:2];
    logic [1:0]        inflight;
    logic [2:0]        occ;
    logic              wr_fire;
    logic              rd_fire;
    logic              issue;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign wr_ready = (ram_cnt != DEPTH);
    assign rd_valid = (buf_cnt != 2'd0);
    assign rd_data  = bmem[bhead];
    assign wr_fire  = wr_valid & wr_ready;
    assign rd_fire  = rd_valid & rd_ready;

    // A word becomes issuable the cycle after its write handshake
    assign avail_eff = avail_cnt + (AWIDTH+1)'(wr_fire_d);
    assign inflight  = 2'(rv_q[0]) + 2'(rv_q[1]);
    assign occ       = 3'(inflight) + 3'(buf_cnt) - 3'(rd_fire);
    assign issue     = (avail_eff != '0) && (occ < 3'd3);

    assign ram_en_a      = rst_n & wr_fire;
    assign ram_write_a   = rst_n & wr_fire;
    assign ram_addr_a    = wptr;
    assign ram_wr_data_a = wr_data;
    assign ram_en_b      = rst_n & issue;
    assign ram_addr_b    = rptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            ram_cnt   <= '0;
            avail_cnt <= '0;
            wr_fire_d <= 1'b0;
            rv_q      <= '0;
            buf_cnt   <= '0;
            bhead     <= '0;
            btail     <= '0;
            count     <= '0;
        end else begin
            if (wr_fire) wptr <= wptr + AWIDTH'(1);
            if (issue) rptr <= rptr + AWIDTH'(1);
            wr_fire_d <= wr_fire;
            ram_cnt   <= ram_cnt + (AWIDTH+1)'(wr_fire) - (AWIDTH+1)'(issue);
            avail_cnt <= avail_eff - (AWIDTH+1)'(issue);
            rv_q      <= {rv_q[0], issue};
            if (rv_q[1]) btail <= nxt(btail);
            if (rd_fire) bhead <= nxt(bhead);
            buf_cnt <= buf_cnt + 2'(rv_q[1]) - 2'(rd_fire);
            count   <= count + (AWIDTH+2)'(wr_fire) - (AWIDTH+2)'(rd_fire);
        end
    end

    // Return data lands at the end of issue cycle + 2
    always_ff @(posedge clk) begin
        if (rst_n && rv_q[1]) bmem[btail] <= ram_rd_data_b;
    end

endmodule

// File: doc/sdpram_fifo_ctrl.md
Name: sdpram_fifo_ctrl

Overview:
- Single-clock synchronous FIFO controller that sequences one infer_sdpram instance (DWIDTH, AWIDTH matched) as the FIFO storage.
- Owns all RAM port-a (write) and port-b (read) control, pointer/occupancy tracking, and the RAM's 2-cycle registered read latency.
- Presents valid/ready streams on both sides; a 3-entry output prefetch buffer sustains 1 word/cycle reads.
- Used wherever the switch fabric buffers cells in block RAM, with clk_a and clk_b of the RAM both tied to clk.

Parameters:
- DWIDTH, 18, data word width; must equal the RAM's DWIDTH.
- AWIDTH, 10, RAM address width; RAM depth = 2**AWIDTH.

Ports:
- clk  in  1  single clock; also drives the RAM clk_a/clk_b.
- rst_n  in  1  reset, synchronous, active-low.
- wr_valid  in  1  producer has a word.
- wr_ready  out  1  controller accepts a word; transfer when wr_valid & wr_ready.
- wr_data  in  DWIDTH  write word.
- rd_valid  out  1  rd_data holds the head word.
- rd_ready  in  1  consumer takes the word; transfer when rd_valid & rd_ready.
- rd_data  out  DWIDTH  head word; driven from the output buffer register.
- count  out  AWIDTH+2  total words held: RAM words not yet read-issued, plus reads in flight, plus output buffer.
- ram_en_a  out  1  to RAM en_a.
- ram_write_a  out  1  to RAM write_a.
- ram_wr_data_a  out  DWIDTH  to RAM wr_data_a.
- ram_addr_a  out  AWIDTH  to RAM addr_a.
- ram_en_b  out  1  to RAM en_b.
- ram_addr_b  out  AWIDTH  to RAM addr_b.
- ram_rd_data_b  in  DWIDTH  from RAM rd_data_b.

Behaviour:
- RAM timing:
  - Write: port-a inputs are registered at edge E; the array is written at E+1.
  - Read: addr_b is registered at E; rd_data_b is valid after E+1.
- Write side:
  - wr_ready = (ram_cnt != 2**AWIDTH).
  - On a write handshake, in the same cycle combinationally: ram_en_a = ram_write_a = 1, ram_addr_a = wptr, ram_wr_data_a = wr_data. wptr increments modulo 2**AWIDTH.
  - ram_en_a = ram_write_a = 0 otherwise.
- Readability: a word is read-issuable one cycle after its write handshake.
  - A registered wr_fire_d adds to avail_cnt.
  - ram_cnt (bounds wr_ready) increments on the write handshake itself.
  - Both counters decrement on read issue.
- Read issue:
  - Condition: avail_cnt != 0 and (inflight + buf_cnt − rd_handshake) < 3.
  - On issue: ram_en_b = 1, ram_addr_b = rptr, rptr increments modulo 2**AWIDTH.
- Read return pipeline:
  - A 2-stage valid shift tracks each issued read.
  - At the end of the issue cycle +2, ram_rd_data_b is written into the 3-entry output FIFO buffer.
  - The word becomes visible on rd_data at issue +3. inflight = number of set valid bits (0..2).
- Output buffer:
  - Holds 3 entries; rd_valid = (buf_cnt != 0).
  - A return and a rd handshake in the same cycle are both honoured (buf_cnt unchanged).
  - The credit rule guarantees the buffer never overflows.
- Latency: a write handshake at cycle 0 into an empty FIFO gives rd_valid = 1 at cycle 4, rd_data = that word. Sustained throughput is 1 word/cycle each side.
- count: +1 on write handshake, −1 on read handshake, unchanged when both occur.
- Full: wr_ready = 0 when ram_cnt = 2**AWIDTH; count may then reach 2**AWIDTH + 3.
- Wrap: pointers wrap 2**AWIDTH−1 → 0 with no bubble.
- Reset (rst_n = 0 at a rising edge, including mid-operation):
  - Cleared to 0: wptr, rptr, ram_cnt, avail_cnt, inflight valids, buf_cnt, count.
  - rd_valid = 0, wr_ready = 1 (from the first cycle after reset).
  - All ram_* enables are 0 while rst_n = 0.
  - In-flight RAM data is discarded; RAM contents are not cleared.

Test Plan:
- Reset state: after rst_n low 2 cycles → rd_valid = 0, wr_ready = 1, count = 0, ram_en_a = ram_en_b = 0.
- Fall-through: write 0x155 at cycle 0 with rd_ready = 1 → ram_en_b at cycle 1, rd_valid and rd_data = 0x155 at cycle 4, count 1 → 0 after the read handshake.
- Full: AWIDTH = 4, rd_ready = 0, write 0..18 continuously → 19 words accepted (16 RAM + 3 buffered); wr_ready drops to 0 with count = 19; one read restores wr_ready within 2 cycles.
- Streaming plus wrap: AWIDTH = 4, 100 words with both sides always ready → after warm-up, one transfer per cycle; output equals input order 0..99 across pointer wrap.
- Random backpressure: random wr_valid/rd_ready at 50% for 2000 cycles → scoreboard matches and the buffer never exceeds 3 entries.
- Reset mid-stream: assert rst_n = 0 while 2 reads are in flight → no rd_valid for the stale data; a new write after reset reads back correctly.
